// File: rtl/bpred_table_arbiter.sv
// -----------------------------------------------------------------------------
// bpred_table_arbiter
//
// Port scheduler for the single-ported TAGE/bimodal table RAMs. Each cycle it
// chooses between a fetch-side lookup (read) and an execute-side update
// (write). Updates are buffered in a small FIFO so fetch is never stalled
// outright. A starvation counter forces a queued update through after
// STARVE_MAX consecutive fetch wins. After reset the block sweeps every table
// index with a zero write before it grants any lookup.
//
// Optional feature macro: BPRED_ARB_BYPASS_EN
//   When defined, an update that arrives while the queue is empty and fetch is
//   idle skips the queue and is written in the same decision cycle.
//
// Ports:
//   clk                        clock
//   reset                      asynchronous active-low reset
//   fetch_req / fetch_PC       lookup request and PC
//   fetch_grant                lookup granted this cycle (combinational)
//   execute_bpredictor_*       update valid, PC+4, direction, miss, metadata
//   upd_ready                  queue can accept an update this cycle
//   tbl_en / tbl_we / tbl_idx  registered table command
//   tbl_wdir/tbl_wmiss/tbl_wdata registered write fields
//   init_busy                  init sweep in progress
//   q_count                    current queue occupancy
// -----------------------------------------------------------------------------
module bpred_table_arbiter #(
    parameter int IDX_W      = 10,
    parameter int Q_DEPTH    = 4,   // power of two, >= 2
    parameter int DATA_W     = 96,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_PC,
    output logic                     fetch_grant,
    input  logic                     execute_bpredictor_update,
    input  logic [31:0]              execute_bpredictor_PC4,
    input  logic                     execute_bpredictor_dir,
    input  logic                     execute_bpredictor_miss,
    input  logic [DATA_W-1:0]        execute_bpredictor_data,
    output logic                     upd_ready,
    output logic                     tbl_en,
    output logic                     tbl_we,
    output logic [IDX_W-1:0]         tbl_idx,
    output logic                     tbl_wdir,
    output logic                     tbl_wmiss,
    output logic [DATA_W-1:0]        tbl_wdata,
    output logic                     init_busy,
    output logic [$clog2(Q_DEPTH):0] q_count
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(Q_DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              dir;
        logic              miss;
        logic [DATA_W-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg,  state_next;
    logic [IDX_W-1:0]   sweep_reg,  sweep_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg,  count_next;
    logic [SC_W-1:0]    starve_reg, starve_next;

    entry_t             q_mem [Q_DEPTH];

    logic               tbl_en_reg,   tbl_en_next;
    logic               tbl_we_reg,   tbl_we_next;
    logic [IDX_W-1:0]   tbl_idx_reg,  tbl_idx_next;
    logic               tbl_wdir_reg, tbl_wdir_next;
    logic               tbl_wmiss_reg, tbl_wmiss_next;
    logic [DATA_W-1:0]  tbl_wdata_reg, tbl_wdata_next;

    // ------------------------------------------------------------------
    // Index arithmetic
    // ------------------------------------------------------------------
    logic [31:0]        upd_pc_m4;
    logic [IDX_W-1:0]   fetch_idx;
    entry_t             upd_entry;
    entry_t             head_entry;

    // PC4 - 4 wraps modulo 2^32, so PC4 = 0 maps to the index of 0xFFFFFFFC.
    assign upd_pc_m4 = execute_bpredictor_PC4 - 32'd4;
    assign fetch_idx = fetch_PC[IDX_W+1:2];

    assign upd_entry.idx  = upd_pc_m4[IDX_W+1:2];
    assign upd_entry.dir  = execute_bpredictor_dir;
    assign upd_entry.miss = execute_bpredictor_miss;
    assign upd_entry.data = execute_bpredictor_data;

    assign head_entry = q_mem[rd_ptr_reg];

    // Address bits outside the table index are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{fetch_PC[31:IDX_W+2], fetch_PC[1:0],
                           upd_pc_m4[31:IDX_W+2], upd_pc_m4[1:0]};

    // ------------------------------------------------------------------
    // Next-state / arbitration
    // ------------------------------------------------------------------
    logic push_any;   // update accepted this cycle
    logic push_q;     // accepted update goes into the queue
    logic pop;        // queue head is written this cycle
    logic bypass;     // accepted update written directly

    always_comb begin
        state_next     = state_reg;
        sweep_next     = sweep_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        starve_next    = starve_reg;

        fetch_grant    = 1'b0;
        upd_ready      = 1'b0;
        push_any       = 1'b0;
        push_q         = 1'b0;
        pop            = 1'b0;
        bypass         = 1'b0;

        tbl_en_next    = 1'b0;
        tbl_we_next    = 1'b0;
        tbl_idx_next   = '0;
        tbl_wdir_next  = 1'b0;
        tbl_wmiss_next = 1'b0;
        tbl_wdata_next = '0;

        case (state_reg)
            ST_INIT: begin
                tbl_en_next = 1'b1;
                tbl_we_next = 1'b1;
                tbl_idx_next = sweep_reg;
                sweep_next  = sweep_reg + IDX_W'(1);
                if (sweep_reg == IDX_LAST) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                // Readiness looks at the current count only: a full queue
                // rejects a push even in a cycle where it also pops.
                upd_ready   = (count_reg < Q_FULL);
                push_any    = execute_bpredictor_update && upd_ready;
                pop         = (count_reg != '0) &&
                              (!fetch_req || (starve_reg == SC_MAX));
                fetch_grant = fetch_req && !pop;
`ifdef BPRED_ARB_BYPASS_EN
                bypass      = push_any && (count_reg == '0) && !fetch_req;
`else
                bypass      = 1'b0;
`endif
                push_q      = push_any && !bypass;

                if (pop) begin
                    tbl_en_next    = 1'b1;
                    tbl_we_next    = 1'b1;
                    tbl_idx_next   = head_entry.idx;
                    tbl_wdir_next  = head_entry.dir;
                    tbl_wmiss_next = head_entry.miss;
                    tbl_wdata_next = head_entry.data;
                end else if (bypass) begin
                    tbl_en_next    = 1'b1;
                    tbl_we_next    = 1'b1;
                    tbl_idx_next   = upd_entry.idx;
                    tbl_wdir_next  = upd_entry.dir;
                    tbl_wmiss_next = upd_entry.miss;
                    tbl_wdata_next = upd_entry.data;
                end else if (fetch_grant) begin
                    tbl_en_next    = 1'b1;
                    tbl_idx_next   = fetch_idx;
                end

                if (push_q) begin
                    wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                end
                case ({push_q, pop})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase

                // Counts fetch wins only while something is waiting.
                if (pop || (count_reg == '0)) begin
                    starve_next = '0;
                end else if (fetch_grant && (starve_reg != SC_MAX)) begin
                    starve_next = starve_reg + SC_W'(1);
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_INIT;
            sweep_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            starve_reg    <= '0;
            tbl_en_reg    <= 1'b0;
            tbl_we_reg    <= 1'b0;
            tbl_idx_reg   <= '0;
            tbl_wdir_reg  <= 1'b0;
            tbl_wmiss_reg <= 1'b0;
            tbl_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_reg     <= sweep_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            starve_reg    <= starve_next;
            tbl_en_reg    <= tbl_en_next;
            tbl_we_reg    <= tbl_we_next;
            tbl_idx_reg   <= tbl_idx_next;
            tbl_wdir_reg  <= tbl_wdir_next;
            tbl_wmiss_reg <= tbl_wmiss_next;
            tbl_wdata_reg <= tbl_wdata_next;
        end
    end

    // Queue storage carries no reset: entries are only ever read below the
    // occupancy count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_q) begin
            q_mem[wr_ptr_reg] <= upd_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tbl_en    = tbl_en_reg;
    assign tbl_we    = tbl_we_reg;
    assign tbl_idx   = tbl_idx_reg;
    assign tbl_wdir  = tbl_wdir_reg;
    assign tbl_wmiss = tbl_wmiss_reg;
    assign tbl_wdata = tbl_wdata_reg;
    assign init_busy = (state_reg == ST_INIT);
    assign q_count   = count_reg;

endmodule

// File: tb/tb_bpred_table_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for bpred_table_arbiter (IDX_W=4, Q_DEPTH=4, STARVE_MAX=8).
// A queue-based reference model predicts the combinational outputs and the
// registered table command every cycle; directed scenarios add hand-computed
// literal expectations on top, followed by a randomized run with occasional
// reset pulses.
// -----------------------------------------------------------------------------
module tb_bpred_table_arbiter;

    localparam int IDX_W      = 4;
    localparam int Q_DEPTH    = 4;
    localparam int DATA_W     = 96;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = $clog2(Q_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_PC = '0;
    logic              fetch_grant;
    logic              upd = 1'b0;
    logic [31:0]       pc4 = '0;
    logic              dir = 1'b0;
    logic              miss = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              upd_ready;
    logic              tbl_en, tbl_we, tbl_wdir, tbl_wmiss, init_busy;
    logic [IDX_W-1:0]  tbl_idx;
    logic [DATA_W-1:0] tbl_wdata;
    logic [CNT_W-1:0]  q_count;

    always #5 clk = ~clk;

    bpred_table_arbiter #(
        .IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_PC(fetch_PC),
        .fetch_grant(fetch_grant),
        .execute_bpredictor_update(upd),
        .execute_bpredictor_PC4(pc4),
        .execute_bpredictor_dir(dir),
        .execute_bpredictor_miss(miss),
        .execute_bpredictor_data(data),
        .upd_ready(upd_ready),
        .tbl_en(tbl_en),
        .tbl_we(tbl_we),
        .tbl_idx(tbl_idx),
        .tbl_wdir(tbl_wdir),
        .tbl_wmiss(tbl_wmiss),
        .tbl_wdata(tbl_wdata),
        .init_busy(init_busy),
        .q_count(q_count)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic              dir;
        logic              miss;
        logic [DATA_W-1:0] data;
    } upd_t;

    upd_t              mq[$];
    bit                m_init;
    int                m_sweep;
    int                m_starve;
    logic              e_en, e_we, e_dir, e_miss;
    logic [IDX_W-1:0]  e_idx;
    logic [DATA_W-1:0] e_data;

    // DUT outputs as sampled in the latest step, for literal checks
    logic              s_grant, s_ready, s_busy, s_en, s_we, s_dir;
    logic [IDX_W-1:0]  s_idx;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W-1:0]  s_qc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_init   = 1'b1;
        m_sweep  = 0;
        m_starve = 0;
        e_en = 0; e_we = 0; e_dir = 0; e_miss = 0; e_idx = '0; e_data = '0;
    endtask

    // One clock cycle: inputs are already driven (at the falling edge).
    task automatic step();
        bit                grant, ready, push, pop, byp;
        upd_t              inc;
        logic [31:0]       pcm4;
        logic              n_en, n_we, n_dir, n_miss;
        logic [IDX_W-1:0]  n_idx;
        logic [DATA_W-1:0] n_data;
        #1;
        if (!reset) model_reset();
        grant = 0; ready = 0; push = 0; pop = 0; byp = 0;
        n_en = 0; n_we = 0; n_dir = 0; n_miss = 0; n_idx = '0; n_data = '0;
        pcm4     = pc4 - 32'd4;
        inc.idx  = pcm4[IDX_W+1:2];
        inc.dir  = dir;
        inc.miss = miss;
        inc.data = data;
        if (reset) begin
            if (m_init) begin
                n_en = 1; n_we = 1; n_idx = m_sweep[IDX_W-1:0];
            end else begin
                ready = (mq.size() < Q_DEPTH);
                push  = upd && ready;
                pop   = (mq.size() > 0) && (!fetch_req || m_starve == STARVE_MAX);
                grant = fetch_req && !pop;
`ifdef BPRED_ARB_BYPASS_EN
                byp   = push && (mq.size() == 0) && !fetch_req;
`endif
                if (pop) begin
                    n_en = 1; n_we = 1; n_idx = mq[0].idx; n_dir = mq[0].dir;
                    n_miss = mq[0].miss; n_data = mq[0].data;
                end else if (byp) begin
                    n_en = 1; n_we = 1; n_idx = inc.idx; n_dir = inc.dir;
                    n_miss = inc.miss; n_data = inc.data;
                end else if (grant) begin
                    n_en = 1; n_idx = fetch_PC[IDX_W+1:2];
                end
            end
        end

        s_grant = fetch_grant; s_ready = upd_ready; s_busy = init_busy;
        s_en = tbl_en; s_we = tbl_we; s_dir = tbl_wdir; s_idx = tbl_idx;
        s_data = tbl_wdata; s_qc = q_count;

        chk("fetch_grant", 128'(fetch_grant), 128'(grant));
        chk("upd_ready",   128'(upd_ready),   128'(ready));
        chk("init_busy",   128'(init_busy),   128'(m_init));
        chk("q_count",     128'(q_count),     128'(mq.size()));
        chk("tbl_en",      128'(tbl_en),      128'(e_en));
        chk("tbl_we",      128'(tbl_we),      128'(e_we));
        if (e_en) chk("tbl_idx", 128'(tbl_idx), 128'(e_idx));
        if (e_we) begin
            chk("tbl_wdir",  128'(tbl_wdir),  128'(e_dir));
            chk("tbl_wmiss", 128'(tbl_wmiss), 128'(e_miss));
            chk("tbl_wdata", 128'(tbl_wdata), 128'(e_data));
            if (!m_init || m_sweep > IDX_W * 0 + (2**IDX_W))
                $display("cycle=%0d write idx=%0h dir=%0b miss=%0b", cyc, tbl_idx, tbl_wdir, tbl_wmiss);
        end
        if (push) $display("cycle=%0d push pc4=%08h idx=%0h byp=%0b", cyc, pc4, inc.idx, byp);

        @(posedge clk);
        if (reset) begin
            if (m_init) begin
                if (m_sweep == 2**IDX_W - 1) m_init = 1'b0;
                m_sweep++;
            end else begin
                if (pop || mq.size() == 0) m_starve = 0;
                else if (grant && m_starve < STARVE_MAX) m_starve++;
                if (pop) void'(mq.pop_front());
                if (push && !byp) mq.push_back(inc);
            end
            e_en = n_en; e_we = n_we; e_idx = n_idx; e_dir = n_dir;
            e_miss = n_miss; e_data = n_data;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [31:0] p, input logic d, input logic m);
        upd  = v;
        pc4  = p;
        dir  = d;
        miss = m;
        data = {$urandom, $urandom, $urandom};
    endtask

    // Release reset and walk the sweep, checking the literal sequence.
    task automatic sweep_check(input string tag);
        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            if (k <= 15) chk({tag, "_grant_blocked"}, 128'(s_grant), 128'(0));
            if (k >= 1) begin
                chk({tag, "_we"},   128'(s_we),   128'(1));
                chk({tag, "_idx"},  128'(s_idx),  128'(k - 1));
                chk({tag, "_data"}, 128'(s_data), 128'(0));
            end
            if (k == 15) chk({tag, "_busy_before_last"}, 128'(s_busy), 128'(1));
            if (k == 16) begin
                chk({tag, "_busy_after_last"}, 128'(s_busy),  128'(0));
                chk({tag, "_ready_rises"},     128'(s_ready), 128'(1));
            end
        end
    endtask

    logic [DATA_W-1:0] d_save;

    initial begin
        model_reset();
        @(negedge clk);

        // Reset state
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("reset_busy",  128'(s_busy),  128'(1));
        chk("reset_en",    128'(s_en),    128'(0));
        chk("reset_qc",    128'(s_qc),    128'(0));
        chk("reset_ready", 128'(s_ready), 128'(0));

        // Init sweep with fetch requesting throughout
        fetch_req = 1'b1;
        fetch_PC  = 32'h0000_1234;
        sweep_check("sweep");
        fetch_req = 1'b0;
        step(); step();

        // Idle update: PC4=0x84 -> idx 0
        set_upd(1, 32'h84, 1, 0);
        d_save = data;
        step();
        upd = 1'b0;
        step();
`ifdef BPRED_ARB_BYPASS_EN
        chk("idle_qc",   128'(s_qc),  128'(0));
        chk("idle_we",   128'(s_we),  128'(1));
        chk("idle_idx",  128'(s_idx), 128'(0));
        chk("idle_dir",  128'(s_dir), 128'(1));
        chk("idle_data", 128'(s_data), 128'(d_save));
        step();
`else
        chk("idle_qc",   128'(s_qc),  128'(1));
        chk("idle_early_we", 128'(s_we), 128'(0));
        step();
        chk("idle_we",   128'(s_we),  128'(1));
        chk("idle_idx",  128'(s_idx), 128'(0));
        chk("idle_dir",  128'(s_dir), 128'(1));
        chk("idle_data", 128'(s_data), 128'(d_save));
`endif
        step();

        // PC wrap: PC4=0 -> idx all ones
        set_upd(1, 32'h0, 0, 1);
        step();
        upd = 1'b0;
        step();
`ifndef BPRED_ARB_BYPASS_EN
        step();
`endif
        chk("wrap_we",  128'(s_we),  128'(1));
        chk("wrap_idx", 128'(s_idx), 128'(4'hF));
        step(); step();

        // Starvation: fetch held, one update queued
        fetch_req = 1'b1;
        fetch_PC  = 32'h0000_0040;
        set_upd(1, 32'h0000_0010, 1, 1);
        step();
        upd = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c <= 8) chk("starve_grant", 128'(s_grant), 128'(1));
            if (c == 9) chk("starve_drop",  128'(s_grant), 128'(0));
            if (c == 10) begin
                chk("starve_resume", 128'(s_grant), 128'(1));
                chk("starve_we",     128'(s_we),    128'(1));
                chk("starve_idx",    128'(s_idx),   128'(3));
            end
        end

        // Full queue: 5 back-to-back pushes while fetch keeps winning
        for (int i = 0; i < 5; i++) begin
            set_upd(1, 32'h100 + 32'(i * 4), i[0], 0);
            step();
            chk("full_ready", 128'(s_ready), 128'(i < 4 ? 1 : 0));
        end
        upd = 1'b0;
        step();
        chk("full_qc", 128'(s_qc), 128'(4));
        fetch_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("drain_qc", 128'(s_qc), 128'(0));

        // Reset mid-operation with three entries queued
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 32'h200 + 32'(i * 4), 1, 1);
            step();
        end
        upd   = 1'b0;
        reset = 1'b0;
        step();
        chk("midrst_qc",   128'(s_qc),   128'(0));
        chk("midrst_busy", 128'(s_busy), 128'(1));
        chk("midrst_en",   128'(s_en),   128'(0));
        fetch_req = 1'b0;
        sweep_check("resweep");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale_write", 128'(s_en), 128'(0));
        end

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            fetch_req = ($urandom_range(0, 3) != 0);
            fetch_PC  = $urandom;
            set_upd(logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 31) == 0) pc4 = 32'h0;
            reset = ($urandom_range(0, 399) != 0);
            step();
        end
        reset = 1'b1;
        upd   = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
